// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the MIPS instruction-fetch front end.
//   fetch_state_e : fetch controller state encoding (BOOT, RUN, HALT)
//   NOP_WORD      : instruction word placed in IF/ID on squash or bubble
//   WORD_BYTES    : size of one instruction word in bytes
// -----------------------------------------------------------------------------
package mips_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_WORD   = 32'h0000_0000;
    localparam logic [31:0] WORD_BYTES = 32'd4;

endpackage : mips_pkg

// File: rtl/pc_register.sv
// -----------------------------------------------------------------------------
// pc_register
// Program counter with its next-PC selection. Priority: reset, load (redirect),
// hold, increment. Every value written is word aligned and wrapped to the
// instruction memory byte range, so bits above that range always read as 0.
//
// Ports
//   Clk        in   system clock
//   Rst        in   synchronous active-high reset, PC <= RESET_PC
//   LoadEn     in   load LoadTarget (branch/jump redirect)
//   LoadTarget in   byte address to load; bits [1:0] and out-of-range bits drop
//   HoldEn     in   keep the current PC
//   Pc         out  current program counter
// -----------------------------------------------------------------------------
module pc_register
    import mips_pkg::*;
#(
    parameter int          IMEM_WORDS = 128,   // must be a power of two
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        LoadEn,
    input  logic [31:0] LoadTarget,
    input  logic        HoldEn,
    output logic [31:0] Pc
);

    // Byte-range mask of the memory with the two byte-offset bits cleared;
    // applying it both aligns and performs the modulo IMEM_WORDS*4 wrap.
    localparam logic [31:0] RANGE_MASK = (32'(IMEM_WORDS) * WORD_BYTES) - 32'd1;
    localparam logic [31:0] ALIGN_MASK = RANGE_MASK & ~32'd3;

    logic [31:0] pc_q;
    logic [31:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (LoadEn) begin
            pc_d = LoadTarget & ALIGN_MASK;
        end else if (!HoldEn) begin
            pc_d = (pc_q + WORD_BYTES) & ALIGN_MASK;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            pc_q <= RESET_PC & ALIGN_MASK;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign Pc = pc_q;

endmodule : pc_register

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
// Instruction-fetch controller: owns the PC (via pc_register), addresses the
// combinational instruction memory and captures the returned word into the
// IF/ID register. Handles stalls, redirects with wrong-path squash, and halt.
//
// Ports
//   Clk             in   system clock
//   Rst             in   synchronous active-high reset, overrides everything
//   Stall           in   hold PC and IF/ID
//   Redirect        in   taken branch/jump; fetch resumes at RedirectTarget
//   RedirectTarget  in   byte address of the new fetch point
//   Halt            in   one-cycle request to stop fetching until reset
//   IMemAddress     out  instruction memory address (the PC)
//   IMemInstruction in   word returned by memory in the same cycle
//   IF_Instruction  out  IF/ID instruction word
//   IF_PCPlus4      out  PC+4 of the captured instruction (not wrapped)
//   IF_Valid        out  IF/ID holds a real, non-squashed instruction
//   FetchCount      out  instructions accepted into IF/ID since reset
//   Halted          out  controller is in HALT
// -----------------------------------------------------------------------------
module fetch_sequencer
    import mips_pkg::*;
#(
    parameter int          IMEM_WORDS = 128,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD   = mips_pkg::NOP_WORD
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Stall,
    input  logic        Redirect,
    input  logic [31:0] RedirectTarget,
    input  logic        Halt,
    output logic [31:0] IMemAddress,
    input  logic [31:0] IMemInstruction,
    output logic [31:0] IF_Instruction,
    output logic [31:0] IF_PCPlus4,
    output logic        IF_Valid,
    output logic [31:0] FetchCount,
    output logic        Halted
);

    fetch_state_e state_q, state_d;
    logic [31:0]  if_instr_q, if_instr_d;
    logic [31:0]  if_pcp4_q,  if_pcp4_d;
    logic         if_valid_q, if_valid_d;
    logic [31:0]  fetch_cnt_q, fetch_cnt_d;

    logic [31:0]  pc;
    logic         pc_load;
    logic         pc_hold;

    pc_register #(
        .IMEM_WORDS (IMEM_WORDS),
        .RESET_PC   (RESET_PC)
    ) u_pc_register (
        .Clk        (Clk),
        .Rst        (Rst),
        .LoadEn     (pc_load),
        .LoadTarget (RedirectTarget),
        .HoldEn     (pc_hold),
        .Pc         (pc)
    );

    // Next-state and IF/ID update. Only RUN moves the PC; BOOT and HALT hold it.
    always_comb begin
        state_d     = state_q;
        if_instr_d  = if_instr_q;
        if_pcp4_d   = if_pcp4_q;
        if_valid_d  = if_valid_q;
        fetch_cnt_d = fetch_cnt_q;
        pc_load     = 1'b0;
        pc_hold     = 1'b1;

        unique case (state_q)
            BOOT: begin
                state_d    = RUN;
                if_valid_d = 1'b0;
            end
            RUN: begin
                if (Halt) begin
                    state_d    = HALT;
                    if_instr_d = NOP_WORD;
                    if_valid_d = 1'b0;
                end else if (Redirect) begin
                    // The word fetched this cycle is wrong-path: squash it.
                    pc_load    = 1'b1;
                    if_instr_d = NOP_WORD;
                    if_valid_d = 1'b0;
                end else if (!Stall) begin
                    pc_hold     = 1'b0;
                    if_instr_d  = IMemInstruction;
                    if_pcp4_d   = pc + WORD_BYTES;  // reported unwrapped
                    if_valid_d  = 1'b1;
                    fetch_cnt_d = fetch_cnt_q + 32'd1;
                end
            end
            HALT: begin
                if_valid_d = 1'b0;
            end
            default: begin
                state_d    = BOOT;
                if_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q     <= BOOT;
            if_instr_q  <= NOP_WORD;
            if_pcp4_q   <= 32'd0;
            if_valid_q  <= 1'b0;
            fetch_cnt_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            if_instr_q  <= if_instr_d;
            if_pcp4_q   <= if_pcp4_d;
            if_valid_q  <= if_valid_d;
            fetch_cnt_q <= fetch_cnt_d;
        end
    end

    assign IMemAddress    = pc;
    assign IF_Instruction = if_instr_q;
    assign IF_PCPlus4     = if_pcp4_q;
    assign IF_Valid       = if_valid_q;
    assign FetchCount     = fetch_cnt_q;
    assign Halted         = (state_q == HALT);

endmodule : fetch_sequencer

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fetch_sequencer
// Self-checking bench for fetch_sequencer: directed scenarios with fixed
// expected values, then randomized traffic against a behavioural model.
// -----------------------------------------------------------------------------
module tb_fetch_sequencer;

    localparam int          WORDS = 128;
    localparam logic [31:0] BYTES = 32'(WORDS * 4);

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        Stall = 1'b0;
    logic        Redirect = 1'b0;
    logic [31:0] RedirectTarget = 32'd0;
    logic        Halt = 1'b0;
    logic [31:0] IMemAddress;
    logic [31:0] IMemInstruction;
    logic [31:0] IF_Instruction;
    logic [31:0] IF_PCPlus4;
    logic        IF_Valid;
    logic [31:0] FetchCount;
    logic        Halted;

    logic [31:0] mem [WORDS];

    fetch_sequencer #(
        .IMEM_WORDS (WORDS),
        .RESET_PC   (32'h0000_0000),
        .NOP_WORD   (32'h0000_0000)
    ) dut (
        .Clk             (Clk),
        .Rst             (Rst),
        .Stall           (Stall),
        .Redirect        (Redirect),
        .RedirectTarget  (RedirectTarget),
        .Halt            (Halt),
        .IMemAddress     (IMemAddress),
        .IMemInstruction (IMemInstruction),
        .IF_Instruction  (IF_Instruction),
        .IF_PCPlus4      (IF_PCPlus4),
        .IF_Valid        (IF_Valid),
        .FetchCount      (FetchCount),
        .Halted          (Halted)
    );

    // Combinational instruction memory.
    assign IMemInstruction = mem[IMemAddress[8:2]];

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] m_pc, m_inst, m_p4, m_cnt;
    logic        m_valid, m_halted, m_boot;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic r, input logic s, input logic rd,
                              input logic [31:0] t, input logic h);
        if (r) begin
            m_pc = 32'd0; m_inst = 32'd0; m_p4 = 32'd0; m_cnt = 32'd0;
            m_valid = 1'b0; m_halted = 1'b0; m_boot = 1'b1;
        end else if (m_halted) begin
            m_valid = 1'b0;
        end else if (m_boot) begin
            m_boot = 1'b0;
        end else if (h) begin
            m_halted = 1'b1; m_inst = 32'd0; m_valid = 1'b0;
        end else if (rd) begin
            m_pc = ((t / 4) * 4) % BYTES;
            m_inst = 32'd0; m_valid = 1'b0;
        end else if (!s) begin
            m_inst  = mem[m_pc / 4];
            m_p4    = m_pc + 4;
            m_valid = 1'b1;
            m_pc    = (m_pc + 4) % BYTES;
            m_cnt   = m_cnt + 1;
        end
    endtask

    task automatic step(input logic r, input logic s, input logic rd,
                        input logic [31:0] t, input logic h);
        Rst = r; Stall = s; Redirect = rd; RedirectTarget = t; Halt = h;
        @(posedge Clk);
        model_edge(r, s, rd, t, h);
        #1;
        check("model_addr",   IMemAddress,          m_pc);
        check("model_inst",   IF_Instruction,       m_inst);
        check("model_pcp4",   IF_PCPlus4,           m_p4);
        check("model_valid",  32'(IF_Valid),        32'(m_valid));
        check("model_count",  FetchCount,           m_cnt);
        check("model_halted", 32'(Halted),          32'(m_halted));
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < WORDS; i++) mem[i] = 32'd0;
        mem[0]   = 32'h2008_0005;
        mem[2]   = 32'hAAAA_0002;
        mem[5]   = 32'h2009_0004;
        mem[10]  = 32'h0109_5020;
        mem[127] = 32'h7F7F_7F7F;

        // Reset values
        step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        check("rst_addr",   IMemAddress, 32'd0);
        check("rst_valid",  32'(IF_Valid), 32'd0);
        check("rst_count",  FetchCount, 32'd0);
        check("rst_inst",   IF_Instruction, 32'd0);
        check("rst_pcp4",   IF_PCPlus4, 32'd0);
        check("rst_halted", 32'(Halted), 32'd0);

        // BOOT cycle, then free run
        idle();
        check("boot_valid", 32'(IF_Valid), 32'd0);
        check("boot_addr",  IMemAddress, 32'd0);
        idle();
        check("first_inst",  IF_Instruction, 32'h2008_0005);
        check("first_pcp4",  IF_PCPlus4, 32'd4);
        check("first_valid", 32'(IF_Valid), 32'd1);
        for (int i = 0; i < 10; i++) idle();
        check("run_count", FetchCount, 32'd11);
        check("run_inst",  IF_Instruction, 32'h0109_5020);
        check("run_pcp4",  IF_PCPlus4, 32'd44);

        // Stall held three cycles at PC=8
        step(1'b0, 1'b0, 1'b1, 32'd8, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
            check("stall_addr",  IMemAddress, 32'd8);
            check("stall_count", FetchCount, 32'd11);
            check("stall_valid", 32'(IF_Valid), 32'd0);
        end
        idle();
        check("unstall_inst",  IF_Instruction, 32'hAAAA_0002);
        check("unstall_count", FetchCount, 32'd12);

        // Redirect with Stall at PC=16, unaligned target 0x2B
        idle();
        check("pre_redir_addr", IMemAddress, 32'd16);
        step(1'b0, 1'b1, 1'b1, 32'h0000_002B, 1'b0);
        check("redir_addr",  IMemAddress, 32'd40);
        check("redir_valid", 32'(IF_Valid), 32'd0);
        check("redir_inst",  IF_Instruction, 32'd0);
        idle();
        check("post_redir_inst", IF_Instruction, 32'h0109_5020);
        check("post_redir_pcp4", IF_PCPlus4, 32'd44);

        // Wrap at the top of memory
        step(1'b0, 1'b0, 1'b1, 32'd508, 1'b0);
        idle();
        check("wrap_inst", IF_Instruction, 32'h7F7F_7F7F);
        check("wrap_pcp4", IF_PCPlus4, 32'd512);
        check("wrap_addr", IMemAddress, 32'd0);

        // Out-of-range target bits are dropped
        step(1'b0, 1'b0, 1'b1, 32'hFFFF_F214, 1'b0);
        check("hi_target_addr", IMemAddress, 32'h0000_0014);

        // Halt at PC=20; nothing moves until reset
        step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        check("halt_flag",  32'(Halted), 32'd1);
        check("halt_valid", 32'(IF_Valid), 32'd0);
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)), $urandom, 1'($urandom_range(1)));
            check("halt_addr", IMemAddress, 32'd20);
            check("halt_hold", 32'(Halted), 32'd1);
        end
        step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        check("unhalt_addr",  IMemAddress, 32'd0);
        check("unhalt_flag",  32'(Halted), 32'd0);
        check("unhalt_count", FetchCount, 32'd0);

        // Reset during an active Redirect + Stall
        idle(); idle(); idle();
        step(1'b1, 1'b1, 1'b1, 32'd100, 1'b0);
        check("rst_mid_addr",  IMemAddress, 32'd0);
        check("rst_mid_count", FetchCount, 32'd0);
        check("rst_mid_valid", 32'(IF_Valid), 32'd0);
        idle();
        check("rst_mid_boot", 32'(IF_Valid), 32'd0);
        idle();
        check("rst_mid_resume_inst",  IF_Instruction, 32'h2008_0005);
        check("rst_mid_resume_valid", 32'(IF_Valid), 32'd1);

        // Randomized traffic against the model
        for (int i = 0; i < WORDS; i++) mem[i] = $urandom;
        for (int i = 0; i < 1500; i++) begin
            step(1'($urandom_range(99) < 2),
                 1'($urandom_range(99) < 25),
                 1'($urandom_range(99) < 12),
                 $urandom,
                 1'($urandom_range(99) < 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_fetch_sequencer
